// File: rtl/spectrum_bin_writer.sv
// rtl/spectrum_bin_writer.sv - peak-hold bin writer feeding port B of the spectrum buffer RAM
// Optional SPECTRUM_PEAK_HOLD_EN: read-modify-write peak hold plus periodic decay; otherwise direct writes.
module spectrum_bin_writer #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int NUM_BINS    = 480,
  parameter int DECAY_STEP  = 1,
  parameter int DECAY_EVERY = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] s_bin,
  input  logic [DATA_W-1:0] s_mag,
  input  logic              s_last,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_ce,
  output logic              ram_wre,
  output logic              ram_oce,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);
  localparam logic [ADDR_W-1:0] BIN_LIMIT = ADDR_W'(NUM_BINS);

`ifdef SPECTRUM_PEAK_HOLD_EN
  typedef enum logic [2:0] {CLR, IDLE, RD, WR, DRD, DWR, DONE} state_t;
  localparam int CNT_W = (DECAY_EVERY > 1) ? $clog2(DECAY_EVERY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECAY_EVERY - 1);
  localparam logic [DATA_W-1:0] STEP     = DATA_W'(DECAY_STEP);
`else
  typedef enum logic [1:0] {CLR, IDLE, DONE} state_t;
`endif

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                w_ready;
  logic                w_hs;
  logic                w_in_range;
  logic                w_ce;
  logic                w_wre;
  logic [ADDR_W-1:0]   w_ad;
  logic [DATA_W-1:0]   w_din;
  logic                w_addr_step;

`ifdef SPECTRUM_PEAK_HOLD_EN
  logic [ADDR_W-1:0]   r_bin;
  logic [DATA_W-1:0]   r_mag;
  logic                r_last;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic                w_eof;
  logic                w_decay_now;
  logic [DATA_W-1:0]   w_peak;
  logic [DATA_W-1:0]   w_decayed;

  assign w_ready     = (r_state == IDLE);
  assign w_decay_now = (r_frame_cnt == CNT_LAST);
  assign w_peak      = (ram_dout > r_mag) ? ram_dout : r_mag;
  assign w_decayed   = (ram_dout > STEP) ? (ram_dout - STEP) : '0;
`else
  logic                w_unused_dout;

  assign w_ready       = (r_state == IDLE) || (r_state == DONE);
  assign w_unused_dout = ^ram_dout;
`endif

  assign w_hs       = s_valid & w_ready;
  assign w_in_range = (s_bin < BIN_LIMIT);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_state <= CLR;
    else            r_state <= w_next;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_addr <= '0;
`ifdef SPECTRUM_PEAK_HOLD_EN
      r_bin       <= '0;
      r_mag       <= '0;
      r_last      <= 1'b0;
      r_frame_cnt <= '0;
`endif
    end else begin
      // The sweep address wraps to 0 so the next clear/decay pass starts at bin 0.
      if (w_addr_step) r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
`ifdef SPECTRUM_PEAK_HOLD_EN
      if (r_state == IDLE && w_hs && w_in_range) begin
        r_bin  <= s_bin;
        r_mag  <= s_mag;
        r_last <= s_last;
      end
      if (w_eof) r_frame_cnt <= w_decay_now ? '0 : r_frame_cnt + 1'b1;
`endif
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ce        = 1'b0;
    w_wre       = 1'b0;
    w_ad        = r_addr;
    w_din       = '0;
    w_addr_step = 1'b0;
`ifdef SPECTRUM_PEAK_HOLD_EN
    w_eof       = 1'b0;
`endif
    case (r_state)
      CLR: begin
        w_ce        = 1'b1;
        w_wre       = 1'b1;
        w_addr_step = 1'b1;
        if (r_addr == LAST_ADDR) w_next = IDLE;
      end
`ifdef SPECTRUM_PEAK_HOLD_EN
      IDLE: begin
        if (w_hs) begin
          if (w_in_range) begin
            w_next = RD;
          end else if (s_last) begin
            w_eof  = 1'b1;
            w_next = w_decay_now ? DRD : DONE;
          end
        end
      end
      RD: begin
        w_ad   = r_bin;
        w_ce   = 1'b1;
        w_next = WR;
      end
      WR: begin
        w_ad  = r_bin;
        w_ce  = 1'b1;
        w_wre = 1'b1;
        w_din = w_peak;
        if (r_last) begin
          w_eof  = 1'b1;
          w_next = w_decay_now ? DRD : DONE;
        end else begin
          w_next = IDLE;
        end
      end
      DRD: begin
        w_ce   = 1'b1;
        w_next = DWR;
      end
      DWR: begin
        w_ce        = 1'b1;
        w_wre       = 1'b1;
        w_din       = w_decayed;
        w_addr_step = 1'b1;
        w_next      = (r_addr == LAST_ADDR) ? DONE : DRD;
      end
      DONE: w_next = IDLE;
`else
      // DONE keeps accepting so the stream never stalls at a frame boundary.
      IDLE, DONE: begin
        w_next = IDLE;
        if (w_hs) begin
          if (w_in_range) begin
            w_ce  = 1'b1;
            w_wre = 1'b1;
            w_ad  = s_bin;
            w_din = s_mag;
          end
          if (s_last) w_next = DONE;
        end
      end
`endif
      default: w_next = CLR;
    endcase
  end

  assign s_ready    = w_ready & sys_rst_n;
  assign ram_ce     = w_ce & sys_rst_n;
  assign ram_wre    = w_wre & sys_rst_n;
  assign ram_ad     = sys_rst_n ? w_ad : '0;
  assign ram_din    = sys_rst_n ? w_din : '0;
  assign ram_oce    = 1'b1;
  assign frame_done = (r_state == DONE) & sys_rst_n;
  assign busy       = (r_state != IDLE);

endmodule

// File: doc/spectrum_bin_writer.md
Name: spectrum_bin_writer

Overview:
- Upstream feeder of the 8-bit x 8K dual-port spectrum buffer RAM. Drives that RAM's port B; the LCD renderer reads port A.
- Accepts per-bin magnitude samples from the FFT magnitude stage over a valid/ready handshake.
- Per bin, performs read-modify-write peak-hold: new = max(old, mag).
- At each frame end, optionally runs a decay sweep over all bins, then signals frame completion to the renderer.

Parameters:
- ADDR_W, 13, RAM address width.
- DATA_W, 8, magnitude/RAM data width.
- NUM_BINS, 480, number of live bins at addresses 0..NUM_BINS-1.
- DECAY_STEP, 1, amount subtracted per decay sweep; saturates at 0.
- DECAY_EVERY, 2, run the decay sweep once per DECAY_EVERY frames (>=1).

Ports:
- sys_clk  in  1  system clock; RAM port B clock.
- sys_rst_n  in  1  synchronous active-low reset.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accept.
- s_bin  in  ADDR_W  bin index.
- s_mag  in  DATA_W  magnitude.
- s_last  in  1  last sample of frame; qualified by s_valid & s_ready.
- ram_ad  out  ADDR_W  port B address.
- ram_din  out  DATA_W  port B write data.
- ram_dout  in  DATA_W  port B read data; valid 1 cycle after the read edge (bypass mode, oce=1).
- ram_ce  out  1  port B clock enable.
- ram_wre  out  1  port B write enable.
- ram_oce  out  1  port B output clock enable; tied 1.
- frame_done  out  1  one-cycle pulse when frame processing completes.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock domain (sys_clk); synchronous active-low reset (sys_rst_n).
- Reset values: s_ready=0, ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0, frame_done=0, busy=1 (FSM enters CLR), frame counter=0.
- FSM states: CLR, IDLE, RD, WR, DRD, DWR, DONE.
- CLR:
  - Writes 0 to addresses 0..NUM_BINS-1, one per cycle (ce=1, wre=1).
  - After the last address, goes to IDLE. Takes NUM_BINS cycles.
- IDLE:
  - s_ready=1.
  - On handshake with s_bin < NUM_BINS: latch bin, mag and last; go to RD.
  - On handshake with s_bin >= NUM_BINS: drop the sample (no RAM access). If s_last=1, go to the end-of-frame path; otherwise stay in IDLE.
- RD: ram_ad=bin, ce=1, wre=0; go to WR.
- WR:
  - ram_dout holds the old value. Write max(old, mag) with ce=1, wre=1.
  - If the latched last=1, take the end-of-frame path; otherwise go to IDLE.
  - Throughput: 1 sample per 3 cycles (IDLE, RD, WR); s_ready low in RD/WR.
- End-of-frame path:
  - Increment the frame counter.
  - If counter == DECAY_EVERY-1: reset the counter and go to DRD at address 0. Otherwise go to DONE.
- Decay sweep:
  - DRD reads address a; DWR writes sat(old - DECAY_STEP).
  - After a = NUM_BINS-1, go to DONE; otherwise a+1 and back to DRD.
  - Sweep length: 2*NUM_BINS cycles.
- DONE: frame_done=1 for exactly one cycle; go to IDLE.
- Arithmetic:
  - max is an unsigned compare.
  - Decay is unsigned; old < DECAY_STEP gives 0. No wrap.
  - Address counter is ADDR_W bits and never exceeds NUM_BINS-1.
- Repeated bin within a frame: each sample is processed independently. Sequential RMW guarantees no lost updates.
- s_last on a dropped sample still ends the frame.
- Reset mid-operation: any state goes to CLR. An in-progress write is abandoned, the frame counter clears, and no frame_done is issued.
- ram_wre=1 only in CLR, WR and DWR; ram_ce=0 in IDLE and DONE.

Optional Feature:
- Macro: SPECTRUM_PEAK_HOLD_EN.
- Defined: peak-hold RMW and decay sweep as described above.
- Undefined:
  - No reads. In IDLE, an accepted in-range sample is written directly (ram_din=s_mag, ce=1, wre=1) in the same cycle.
  - s_ready stays 1 continuously; throughput is 1 sample/cycle.
  - RD/WR/DRD/DWR and the frame counter are removed.
  - s_last goes to DONE, so frame_done pulses the cycle after the s_last handshake.
  - CLR is retained.

Test Plan:
- Reset release -> busy=1 for 480 cycles; every address 0..479 written with 0; then s_ready=1.
- Bin 5 mag 0x40, then bin 5 mag 0x20 -> RAM[5]=0x40 after both; next s_ready 3 cycles after each handshake.
- Frame with bin 7 mag 0x03 and s_last, DECAY_STEP=1, DECAY_EVERY=1 -> after sweep RAM[7]=0x02, RAM[0]=0x00 (saturated); frame_done 1 cycle.
- s_bin=600 with s_last=1 -> no ram_wre on the sample; end-of-frame path runs; frame_done pulses; RAM unchanged except decay.
- DECAY_EVERY=2: two frames -> sweep only after the second; frame_done after each.
- sys_rst_n low during a DWR sweep -> CLR restarts; no frame_done; all bins end at 0. Without SPECTRUM_PEAK_HOLD_EN: back-to-back samples -> 1 write/cycle, s_ready stays 1.
